id_delay_timer: RTL and testbench

- Downstream consumer of the student-ID mod-3 sequencer in the timer design.
- On a start request, it pulses the sequencer's next-request input and captures the current mod-3 digit.
- It converts that digit into a delay of (BASE_UNITS + digit) * UNIT_TICKS tick periods, counts the delay down on an external tick enable, and then reports completion.
- The ID sequence therefore drives the variable wait periods of the timer.

---
 rtl/id_delay_timer.sv | 133 +++++++++++++
 tb/tb_id_delay_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_delay_timer.sv
// id_delay_timer: on each accepted start, asks the ID sequencer to advance,
// captures the pre-advance mod-3 digit and waits (BASE_UNITS + digit) *
// UNIT_TICKS tick periods before pulsing oDone.
// Optional abort input/output enabled by defining ID_DELAY_TIMER_ABORT_EN.
module id_delay_timer #(
    parameter int unsigned UNIT_TICKS = 1000,
    parameter int unsigned BASE_UNITS = 1,
    parameter int unsigned CNT_W      = 12
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iTick,
    input  logic [1:0]       iIDmod3,
`ifdef ID_DELAY_TIMER_ABORT_EN
    input  logic             iAbort,
    output logic             oAborted,
`endif
    output logic             oNext,
    output logic             oBusy,
    output logic             oDone,
    output logic [CNT_W-1:0] oRemain,
    output logic [1:0]       oIDLatched
);

    // The longest delay (digit 2, plus headroom for the illegal code) must fit the counter.
    if ((longint'(BASE_UNITS) + 64'd3) * longint'(UNIT_TICKS) >= (64'd1 << CNT_W)) begin : g_cfg_check
        $error("id_delay_timer: CNT_W too narrow for (BASE_UNITS+3)*UNIT_TICKS");
    end

    // Per-digit delay lengths are elaboration constants; no runtime multiplier.
    localparam logic [CNT_W-1:0] Load0 = CNT_W'((BASE_UNITS + 0) * UNIT_TICKS);
    localparam logic [CNT_W-1:0] Load1 = CNT_W'((BASE_UNITS + 1) * UNIT_TICKS);
    localparam logic [CNT_W-1:0] Load2 = CNT_W'((BASE_UNITS + 2) * UNIT_TICKS);

    typedef enum logic [1:0] {StIdle, StReq, StCount, StDone} state_e;

    state_e             state_q, state_d;
    logic               next_q, next_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [1:0]         id_q, id_d;
    logic [CNT_W-1:0]   load_val;
`ifdef ID_DELAY_TIMER_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    // Map the sampled digit to its delay; the illegal code 3 behaves as 0.
    always_comb begin
        load_val = Load0;
        case (iIDmod3)
            2'd1:    load_val = Load1;
            2'd2:    load_val = Load2;
            default: load_val = Load0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        id_d     = id_q;
`ifdef ID_DELAY_TIMER_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (iStart) state_d = StReq;
            end
            StReq: begin
                // Sequencer advances on this same edge, so this is the pre-advance digit.
                id_d     = iIDmod3;
                remain_d = load_val;
                state_d  = StCount;
            end
            StCount: begin
                if (iTick) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = StDone;
                end
            end
            StDone: begin
                remain_d = '0;
                state_d  = iStart ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef ID_DELAY_TIMER_ABORT_EN
        // Abort only cancels an active delay; the REQ digit is still consumed.
        if (iAbort && (state_q == StReq || state_q == StCount)) begin
            state_d   = StIdle;
            remain_d  = '0;
            aborted_d = 1'b1;
        end
`endif
        // Registered pulses track the state being entered.
        next_d = (state_d == StReq);
        done_d = (state_d == StDone);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= StIdle;
            next_q   <= 1'b0;
            done_q   <= 1'b0;
            remain_q <= '0;
            id_q     <= 2'd0;
`ifdef ID_DELAY_TIMER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            next_q   <= next_d;
            done_q   <= done_d;
            remain_q <= remain_d;
            id_q     <= id_d;
`ifdef ID_DELAY_TIMER_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign oNext      = next_q;
    assign oBusy      = (state_q == StReq) || (state_q == StCount);
    assign oDone      = done_q;
    assign oRemain    = remain_q;
    assign oIDLatched = id_q;
`ifdef ID_DELAY_TIMER_ABORT_EN
    assign oAborted   = aborted_q;
`endif

endmodule

// File: tb/tb_id_delay_timer.sv
// Testbench for id_delay_timer with a behavioural ID sequencer attached.
module tb_id_delay_timer;

    localparam int UnitTicks = 4;
    localparam int BaseUnits = 1;
    localparam int CntW      = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            tick = 1'b0;
    logic [1:0]      id_mod3;
    logic            nxt, busy, done;
    logic [CntW-1:0] remain;
    logic [1:0]      id_latched;
`ifdef ID_DELAY_TIMER_ABORT_EN
    logic            abort = 1'b0;
    logic            aborted;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;   // delays accepted since the last reset
    int next_cnt = 0;
    int done_cnt = 0;
    logic [2:0] seq_idx = 3'd0;

    always #5 clk = ~clk;

    id_delay_timer #(
        .UNIT_TICKS (UnitTicks),
        .BASE_UNITS (BaseUnits),
        .CNT_W      (CntW)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iStart     (start),
        .iTick      (tick),
        .iIDmod3    (id_mod3),
`ifdef ID_DELAY_TIMER_ABORT_EN
        .iAbort     (abort),
        .oAborted   (aborted),
`endif
        .oNext      (nxt),
        .oBusy      (busy),
        .oDone      (done),
        .oRemain    (remain),
        .oIDLatched (id_latched)
    );

    // Post-reset digit order of the real sequencer.
    function automatic logic [1:0] seq_digit(input int i);
        case (i % 8)
            0: return 2'd2;
            1: return 2'd1;
            2: return 2'd2;
            3: return 2'd1;
            4: return 2'd2;
            5: return 2'd0;
            6: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Sequencer model: advances on oNext, reset with the timer.
    always @(posedge clk) begin
        if (rst) seq_idx <= 3'd0;
        else if (nxt) seq_idx <= seq_idx + 3'd1;
        if (nxt) next_cnt <= next_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end
    assign id_mod3 = seq_digit(int'(seq_idx));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int delay_len(input int i);
        return (BaseUnits + int'(seq_digit(i))) * UnitTicks;
    endfunction

    // One full delay with random ticks, checked against the delay arithmetic.
    task automatic run_delay();
        int rem;
        int cyc;
        logic [1:0] d;
        d = seq_digit(k);
        chk("idle_no_next", 32'(nxt), 0);
        start = 1'b1;
        tick  = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        chk("req_next", 32'(nxt), 1);
        chk("req_busy", 32'(busy), 1);
        tick = 1'($urandom_range(0, 1));   // must be ignored in REQ
        step();
        rem = delay_len(k);
        k++;
        chk("latched", 32'(id_latched), 32'(d));
        chk("load", 32'(remain), rem);
        chk("next_once", 32'(nxt), 0);
        cyc = 0;
        while (rem > 0 && cyc < 1000) begin
            tick = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (tick) rem--;
            if (rem > 0) begin
                chk("remain", 32'(remain), rem);
                chk("no_done", 32'(done), 0);
                chk("no_next_count", 32'(nxt), 0);
            end
        end
        chk("done", 32'(done), 1);
        chk("remain0", 32'(remain), 0);
        tick = 1'b0;
        step();
        chk("done_once", 32'(done), 0);
        chk("back_idle", 32'(busy), 0);
        chk("seq_adv", 32'(seq_idx), k % 8);
    endtask

    initial begin
        int rem;
        int n;
        int nreq;
        int next0;
        int done0;
        int exp_next[$];
        int exp_done[$];

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_next", 32'(nxt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_remain", 32'(remain), 0);
        chk("rst_latched", 32'(id_latched), 0);
        rst = 1'b0;
        k = 0;
        step();

        // Six starts: remain loads 12,8,12,8,12,4
        for (int i = 0; i < 6; i++) run_delay();
        chk("latched_hold", 32'(id_latched), 32'(seq_digit(5)));

        // Reset mid-COUNT at oRemain=5
        start = 1'b1;
        step();
        start = 1'b0;
        tick = 1'b0;
        step();
        rem = delay_len(k);
        k++;
        while (rem > 5) begin
            tick = 1'b1;
            step();
            rem--;
        end
        tick = 1'b0;
        chk("pre_rst_remain", 32'(remain), 5);
        rst = 1'b1;
        step();
        chk("mid_rst_next", 32'(nxt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_remain", 32'(remain), 0);
        chk("mid_rst_latched", 32'(id_latched), 0);
        rst = 1'b0;
        k = 0;
        step();
        chk("post_rst_no_done", 32'(done), 0);
        run_delay();   // sequencer restarted: digit 2

        // Tick held high from start: done after REQ + count + 1 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        k = 0;
        step();
        start = 1'b1;
        tick  = 1'b1;
        n = 0;
        do begin
            step();
            start = 1'b0;
            n++;
        end while (!done && n < 200);
        chk("tick_hold_latency", n, 2 + delay_len(k));
        k++;
        tick = 1'b0;
        step();

        // iStart held 40 cycles, tick always high: back-to-back delays
        for (int j = k; exp_next.size() < 40; j++) begin
            exp_next.push_back(1);
            exp_done.push_back(0);
            for (int t = 0; t < delay_len(j); t++) begin
                exp_next.push_back(0);
                exp_done.push_back(0);
            end
            exp_next.push_back(0);
            exp_done.push_back(1);
        end
        next0 = next_cnt;
        done0 = done_cnt;
        nreq  = 0;
        start = 1'b1;
        tick  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("hold_next", 32'(nxt), exp_next[i]);
            chk("hold_done", 32'(done), exp_done[i]);
            nreq += exp_next[i];
        end
        start = 1'b0;
        k += nreq;
        n = 0;
        while ((busy || done) && n < 100) begin
            step();
            n++;
        end
        tick = 1'b0;
        step();
        chk("hold_drained", 32'(busy), 0);
        chk("hold_next_eq_done", next_cnt - next0, done_cnt - done0);
        chk("hold_next_count", next_cnt - next0, nreq);
        chk("hold_seq_adv", 32'(seq_idx), k % 8);

`ifdef ID_DELAY_TIMER_ABORT_EN
        // Abort in COUNT at oRemain=7
        while (delay_len(k) <= 7) run_delay();
        done0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rem = delay_len(k);
        k++;
        while (rem > 7) begin
            tick = 1'b1;
            step();
            rem--;
        end
        tick = 1'b0;
        chk("pre_abort_remain", 32'(remain), 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("aborted", 32'(aborted), 1);
        chk("abort_remain", 32'(remain), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_no_done", 32'(done), 0);
        step();
        chk("aborted_once", 32'(aborted), 0);
        chk("abort_done_cnt", done_cnt - done0, 0);
        run_delay();   // next digit in sequence
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
